// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time memory loader.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loaderState_e;

  localparam int DEFAULT_ADDR_STEP = 4;
  localparam int BYTES_PER_WORD    = 4;
  localparam int BYTE_IDX_W        = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/word_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// Byte k of a word lands in bits [8k+7:8k]; the index wraps after the last byte.
module word_packer
  import loader_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          byteXfer,
  input  logic [7:0]                    byteIn,
  output logic [8*BYTES_PER_WORD-1:0]   wordData,
  output logic                          lastByte
);

  logic [BYTE_IDX_W-1:0] byteIdx;

  // Place each transferred byte at its lane and advance the byte index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byteIdx  <= '0;
      wordData <= '0;
    end else if (byteXfer) begin
      wordData[8*byteIdx +: 8] <= byteIn;
      byteIdx                  <= byteIdx + BYTE_IDX_W'(1);
    end
  end

  assign lastByte = (byteIdx == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/mem_loader.sv
// Loads a byte stream into data memory as 32-bit words, holding the CPU in
// reset until the requested number of words has been written.
module mem_loader
  import loader_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int ADDR_STEP = DEFAULT_ADDR_STEP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_adr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             Ext_MemWrite,
  output logic [31:0]      Ext_WriteData,
  output logic [31:0]      Ext_DataAdr,
  output logic             cpu_reset,
  output logic             done
);

  loaderState_e     state, nextState;
  logic [CNT_W-1:0] wordCnt;
  logic             byteXfer;
  logic             lastByte;
  logic             startAcc;

  assign byteXfer = in_valid && in_ready;

  word_packer uPacker (
    .clk      (clk),
    .reset    (reset),
    .byteXfer (byteXfer),
    .byteIn   (in_data),
    .wordData (Ext_WriteData),
    .lastByte (lastByte)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state and Moore outputs; start is only honoured in IDLE and DONE.
  always_comb begin
    nextState    = state;
    in_ready     = 1'b0;
    Ext_MemWrite = 1'b0;
    done         = 1'b0;
    cpu_reset    = 1'b1;
    startAcc     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          startAcc  = 1'b1;
          nextState = (word_count == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        in_ready = 1'b1;
        if (in_valid && lastByte) nextState = WRITE;
      end
      WRITE: begin
        Ext_MemWrite = 1'b1;
        nextState    = (wordCnt == CNT_W'(1)) ? DONE : RECV;
      end
      DONE: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
        if (start) begin
          startAcc  = 1'b1;
          nextState = (word_count == '0) ? DONE : RECV;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Address and remaining-word counter: load on a non-empty start, step after
  // each write. An empty start leaves them alone so DONE outputs stay put.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Ext_DataAdr <= '0;
      wordCnt     <= '0;
    end else if (startAcc && (word_count != '0)) begin
      Ext_DataAdr <= base_adr;
      wordCnt     <= word_count;
    end else if (state == WRITE) begin
      Ext_DataAdr <= Ext_DataAdr + 32'(ADDR_STEP);
      wordCnt     <= wordCnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_adr;
  logic [15:0] word_count;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        Ext_MemWrite;
  logic [31:0] Ext_WriteData;
  logic [31:0] Ext_DataAdr;
  logic        cpu_reset;
  logic        done;

  int compared = 0;
  int mism     = 0;
  int cyc      = 0;

  logic [31:0] qAdr[$];
  logic [31:0] qDat[$];
  int          qCyc[$];
  logic        qRdy[$];

  mem_loader #(.CNT_W(16), .ADDR_STEP(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_adr      (base_adr),
    .word_count    (word_count),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .Ext_MemWrite  (Ext_MemWrite),
    .Ext_WriteData (Ext_WriteData),
    .Ext_DataAdr   (Ext_DataAdr),
    .cpu_reset     (cpu_reset),
    .done          (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write strobe seen mid-cycle.
  always @(negedge clk) begin
    if (Ext_MemWrite === 1'b1) begin
      qAdr.push_back(Ext_DataAdr);
      qDat.push_back(Ext_WriteData);
      qCyc.push_back(cyc);
      qRdy.push_back(in_ready);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clearQ();
    qAdr.delete();
    qDat.delete();
    qCyc.delete();
    qRdy.delete();
  endtask

  task automatic pulseStart(input logic [31:0] b, input logic [15:0] n);
    base_adr   = b;
    word_count = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int g;
    in_valid = 1'b1;
    in_data  = b;
    g = 0;
    while (in_ready !== 1'b1 && g < 20) begin
      tick();
      g++;
    end
    if (in_ready !== 1'b1) chk("rdyTimeout", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Gappy mode inserts an idle cycle before every byte carrying a bogus start.
  task automatic sendWord(input logic [31:0] w, input bit gappy);
    for (int k = 0; k < 4; k++) begin
      if (gappy) begin
        in_valid   = 1'b0;
        in_data    = 8'hEE;
        base_adr   = 32'hDEAD_0000;
        word_count = 16'd7;
        start      = 1'b1;
        tick();
        start      = 1'b0;
      end
      sendByte(w[8*k +: 8]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w0, w1, w2;
    w0 = 32'h1122_3344;
    w1 = 32'hA5A5_5A5A;
    w2 = 32'h00FF_7F80;

    reset = 1'b0; start = 1'b0; base_adr = '0; word_count = '0;
    in_valid = 1'b0; in_data = '0;
    tick(); tick();
    // Reset state
    chk("rst_inReady",  {31'd0, in_ready},     32'd0);
    chk("rst_memWrite", {31'd0, Ext_MemWrite}, 32'd0);
    chk("rst_done",     {31'd0, done},         32'd0);
    chk("rst_cpuReset", {31'd0, cpu_reset},    32'd1);
    chk("rst_adr",      Ext_DataAdr,           32'd0);
    chk("rst_data",     Ext_WriteData,         32'd0);
    reset = 1'b1;
    tick();
    chk("idle_cpuReset", {31'd0, cpu_reset}, 32'd1);

    // Single word load
    clearQ();
    pulseStart(32'h0000_0100, 16'd1);
    chk("t1_inReady", {31'd0, in_ready}, 32'd1);
    sendByte(8'h13); sendByte(8'h05); sendByte(8'h50); sendByte(8'h00);
    chk("t1_memWrite", {31'd0, Ext_MemWrite}, 32'd1);
    chk("t1_adr",      Ext_DataAdr,           32'h0000_0100);
    chk("t1_data",     Ext_WriteData,         32'h0050_0513);
    chk("t1_wrReady",  {31'd0, in_ready},     32'd0);
    tick();
    chk("t1_done",     {31'd0, done},         32'd1);
    chk("t1_cpuReset", {31'd0, cpu_reset},    32'd0);
    chk("t1_memWrOff", {31'd0, Ext_MemWrite}, 32'd0);
    chk("t1_nStrobe",  qAdr.size(),           32'd1);

    // Three back-to-back words from DONE
    clearQ();
    pulseStart(32'h0, 16'd3);
    chk("t2_cpuReset", {31'd0, cpu_reset}, 32'd1);
    chk("t2_done",     {31'd0, done},      32'd0);
    sendWord(w0, 1'b0); sendWord(w1, 1'b0); sendWord(w2, 1'b0);
    tick();
    chk("t2_nStrobe", qAdr.size(), 32'd3);
    if (qAdr.size() == 3) begin
      chk("t2_adr0", qAdr[0], 32'h0); chk("t2_dat0", qDat[0], w0);
      chk("t2_adr1", qAdr[1], 32'h4); chk("t2_dat1", qDat[1], w1);
      chk("t2_adr2", qAdr[2], 32'h8); chk("t2_dat2", qDat[2], w2);
      chk("t2_gap01", qCyc[1] - qCyc[0], 32'd5);
      chk("t2_gap12", qCyc[2] - qCyc[1], 32'd5);
      chk("t2_rdy0", {31'd0, qRdy[0]}, 32'd0);
      chk("t2_rdy1", {31'd0, qRdy[1]}, 32'd0);
      chk("t2_rdy2", {31'd0, qRdy[2]}, 32'd0);
    end
    chk("t2_done2", {31'd0, done}, 32'd1);

    // Address wrap
    clearQ();
    pulseStart(32'hFFFF_FFFC, 16'd2);
    sendWord(32'hCAFE_F00D, 1'b0); sendWord(32'h1234_5678, 1'b0);
    tick();
    chk("t3_nStrobe", qAdr.size(), 32'd2);
    if (qAdr.size() == 2) begin
      chk("t3_adr0", qAdr[0], 32'hFFFF_FFFC); chk("t3_dat0", qDat[0], 32'hCAFE_F00D);
      chk("t3_adr1", qAdr[1], 32'h0000_0000); chk("t3_dat1", qDat[1], 32'h1234_5678);
    end

    // Empty load from IDLE, then from DONE
    reset = 1'b0; tick(); reset = 1'b1; tick();
    chk("t4_idleDone", {31'd0, done}, 32'd0);
    clearQ();
    pulseStart(32'h40, 16'd0);
    chk("t4_done",     {31'd0, done},      32'd1);
    chk("t4_cpuReset", {31'd0, cpu_reset}, 32'd0);
    chk("t4_inReady",  {31'd0, in_ready},  32'd0);
    pulseStart(32'h80, 16'd0);
    chk("t4_stayDone", {31'd0, done},      32'd1);
    tick();
    chk("t4_nStrobe",  qAdr.size(),        32'd0);

    // Reset mid-word, then a fresh load
    clearQ();
    pulseStart(32'h200, 16'd2);
    sendByte(8'h01); sendByte(8'h02);
    #2 reset = 1'b0;
    #1;
    chk("t5_inReady",  {31'd0, in_ready},     32'd0);
    chk("t5_data",     Ext_WriteData,         32'd0);
    chk("t5_adr",      Ext_DataAdr,           32'd0);
    chk("t5_cpuReset", {31'd0, cpu_reset},    32'd1);
    chk("t5_done",     {31'd0, done},         32'd0);
    chk("t5_memWrite", {31'd0, Ext_MemWrite}, 32'd0);
    in_valid = 1'b1; in_data = 8'h77;
    tick(); tick();
    reset = 1'b1;
    tick(); tick(); tick();
    chk("t5_idleReady", {31'd0, in_ready}, 32'd0);
    chk("t5_noConsume", Ext_WriteData,     32'd0);
    chk("t5_noStrobe",  qAdr.size(),       32'd0);
    in_valid = 1'b0;
    pulseStart(32'h300, 16'd1);
    sendWord(32'hDDCC_BBAA, 1'b0);
    tick();
    chk("t5_nStrobe", qAdr.size(), 32'd1);
    if (qAdr.size() == 1) begin
      chk("t5_sAdr", qAdr[0], 32'h300);
      chk("t5_sDat", qDat[0], 32'hDDCC_BBAA);
    end
    chk("t5_doneAfter", {31'd0, done}, 32'd1);

    // Gappy stream with start pulses mid-load
    clearQ();
    pulseStart(32'h1000, 16'd3);
    sendWord(w0, 1'b1); sendWord(w1, 1'b1); sendWord(w2, 1'b1);
    tick();
    chk("t6_nStrobe", qAdr.size(), 32'd3);
    if (qAdr.size() == 3) begin
      chk("t6_adr0", qAdr[0], 32'h1000); chk("t6_dat0", qDat[0], w0);
      chk("t6_adr1", qAdr[1], 32'h1004); chk("t6_dat1", qDat[1], w1);
      chk("t6_adr2", qAdr[2], 32'h1008); chk("t6_dat2", qDat[2], w2);
    end
    chk("t6_done", {31'd0, done}, 32'd1);
    tick(); tick();
    chk("t6_holdAdr", Ext_DataAdr, 32'h100C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
